// File: rtl/mem_stream_reader_pkg.sv
// Shared types and default widths for the buffer-memory read initiator.
//   rd_state_t  : read FSM states
//   DEF_*       : default address/data/length widths
package conveng_mem_pkg;

    localparam int unsigned DEF_ADDRW = 10;
    localparam int unsigned DEF_DATAW = 8;
    localparam int unsigned DEF_LENW  = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;

endpackage

// File: rtl/mem_stream_reader_if.sv
// Command and output-stream handshake bundle for mem_stream_reader.
//   cmd_valid/cmd_ready/cmd_addr/cmd_len : burst command channel
//   out_valid/out_ready/out_data/out_last : returned word stream
// master = command issuer / stream consumer, slave = the reader.
interface mem_stream_reader_if
    import conveng_mem_pkg::*;
#(
    parameter int unsigned ADDRW = DEF_ADDRW,
    parameter int unsigned DATAW = DEF_DATAW,
    parameter int unsigned LENW  = DEF_LENW
) ();

    logic             cmd_valid;
    logic             cmd_ready;
    logic [ADDRW-1:0] cmd_addr;
    logic [LENW-1:0]  cmd_len;

    logic             out_valid;
    logic             out_ready;
    logic [DATAW-1:0] out_data;
    logic             out_last;

    modport master (
        output cmd_valid, cmd_addr, cmd_len,
        input  cmd_ready,
        input  out_valid, out_data, out_last,
        output out_ready
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_len,
        output cmd_ready,
        output out_valid, out_data, out_last,
        input  out_ready
    );

endinterface

// File: rtl/mem_rd_skid.sv
// Two-entry FIFO buffering returned read words (data plus last tag).
//   clk, rst_n  : clock, synchronous active-low reset
//   push/push_data : write one entry
//   pop         : remove head entry
//   head        : current head entry
//   count       : occupancy 0..2
// Simultaneous push and pop keeps the count and preserves order.
module mem_rd_skid #(
    parameter int unsigned W = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/mem_stream_reader.sv
// Burst read initiator for a 1R1W buffer memory with 1-cycle registered read.
//   clk, rst_n   : clock, synchronous active-low reset
//   bus (slave)  : command channel in, valid/ready word stream out with last flag
//   mem_rd_addr  : registered read address to memory
//   mem_rd_data  : read data, valid the cycle after the address is sampled
//   busy         : FSM not idle
//   done         : one-cycle pulse at burst completion
module mem_stream_reader
    import conveng_mem_pkg::*;
#(
    parameter int unsigned ADDRW = DEF_ADDRW,
    parameter int unsigned DATAW = DEF_DATAW,
    parameter int unsigned LENW  = DEF_LENW
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_stream_reader_if.slave  bus,
    output logic [ADDRW-1:0]    mem_rd_addr,
    input  logic [DATAW-1:0]    mem_rd_data,
    output logic                busy,
    output logic                done
);

    rd_state_t        state;
    logic [LENW-1:0]  remaining;
    logic             inflight;
    logic             inflight_last;

    logic             accept;
    logic             pop;
    logic             issue_en;
    logic             last_issue;
    logic             drain_done;
    logic [2:0]       occ;
    logic [1:0]       skid_count;
    logic [DATAW:0]   skid_head;

    assign bus.cmd_ready = (state == IDLE);
    assign accept        = bus.cmd_valid & bus.cmd_ready;
    assign bus.out_valid = (skid_count != 2'd0);
    assign pop           = bus.out_valid & bus.out_ready;
    assign bus.out_data  = skid_head[DATAW-1:0];
    assign bus.out_last  = skid_head[DATAW];
    assign busy          = (state != IDLE);

    // Credit: a read issued now lands in the FIFO next cycle, so the words
    // already buffered plus the one in flight, less this cycle's pop, must
    // leave a free slot.
    always_comb begin
        occ        = 3'(skid_count) + 3'(inflight);
        issue_en   = (state == ISSUE) && (occ < (3'd2 + 3'(pop)));
        last_issue = issue_en && (remaining == LENW'(1));
        // Completes on the edge that pops the final buffered word.
        drain_done = (state == DRAIN) && !inflight &&
                     ((skid_count == 2'd0) || ((skid_count == 2'd1) && pop));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            mem_rd_addr   <= '0;
            remaining     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            done          <= 1'b0;
        end else begin
            done          <= 1'b0;
            inflight      <= issue_en;
            inflight_last <= last_issue;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        mem_rd_addr <= bus.cmd_addr;
                        remaining   <= bus.cmd_len;
                        if (bus.cmd_len == '0) begin
                            done <= 1'b1;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (issue_en) begin
                        mem_rd_addr <= mem_rd_addr + ADDRW'(1);
                        remaining   <= remaining - LENW'(1);
                        if (remaining == LENW'(1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_done) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    mem_rd_skid #(
        .W(DATAW + 1)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight),
        .push_data ({inflight_last, mem_rd_data}),
        .pop       (pop),
        .head      (skid_head),
        .count     (skid_count)
    );

endmodule

// File: tb/tb_mem_stream_reader.sv
// Scoreboard bench for mem_stream_reader with a registered-read memory model
// preloaded as ram[i] = i mod 256.
module tb_mem_stream_reader;
    import conveng_mem_pkg::*;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 8;
    localparam int unsigned LW = 11;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    mem_stream_reader_if #(.ADDRW(AW), .DATAW(DW), .LENW(LW)) bus ();

    mem_stream_reader #(
        .ADDRW(AW),
        .DATAW(DW),
        .LENW (LW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .busy        (busy),
        .done        (done)
    );

    // Generic memory: registered read, one cycle latency.
    logic [DW-1:0] ram [1 << AW];
    initial begin
        for (int i = 0; i < (1 << AW); i++) ram[i] = DW'(i);
    end
    always @(posedge clk) mem_rd_data <= ram[mem_rd_addr];

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int cyc = 0;
    int accept_cyc = 0;
    int last_pop_cyc = 0;
    int done_cnt = 0;
    int words_popped = 0;
    logic [DW:0] exp_q [$];

    task automatic check(input string name, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && bus.cmd_valid && bus.cmd_ready) accept_cyc <= cyc + 1;
        if (rst_n && bus.out_valid && bus.out_ready && bus.out_last) last_pop_cyc <= cyc + 1;
    end

    // Monitor: pops expected words on each handshake, checks stall stability.
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    always @(negedge clk) begin
        logic [DW:0] e;
        if (rst_n) begin
            if (prev_stall) begin
                check("stall_valid", int'(bus.out_valid), 1);
                check("stall_data", int'(bus.out_data), int'(prev_data));
                check("stall_last", int'(bus.out_last), int'(prev_last));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_word_queue_size", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("word_data", int'(bus.out_data), int'(e[DW-1:0]));
                    check("word_last", int'(bus.out_last), int'(e[DW]));
                    words_popped++;
                end
            end
            if (done) done_cnt++;
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_last  = bus.out_last;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic send_cmd(input int unsigned addr, input int unsigned len);
        logic [AW-1:0] a;
        bit got = 0;
        for (int unsigned i = 0; i < len; i++) begin
            a = AW'(addr + i);
            exp_q.push_back({(i == len - 1), a[DW-1:0]});
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = AW'(addr);
        bus.cmd_len   = LW'(len);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.cmd_ready) begin
                got = 1;
                break;
            end
        end
        check("cmd_accept_timeout", int'(got), 1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input bit zero_len);
        bit found = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done) begin
                found = 1;
                break;
            end
        end
        check({name, "_done_seen"}, int'(found), 1);
        if (found) begin
            check({name, "_done_time"}, cyc, zero_len ? accept_cyc : last_pop_cyc);
            check({name, "_cmd_ready"}, int'(bus.cmd_ready), 1);
            @(negedge clk);
            check({name, "_done_pulse"}, int'(done), 0);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_cmd_ready"}, int'(bus.cmd_ready), 1);
        check({name, "_out_valid"}, int'(bus.out_valid), 0);
        check({name, "_out_data"}, int'(bus.out_data), 0);
        check({name, "_out_last"}, int'(bus.out_last), 0);
        check({name, "_busy"}, int'(busy), 0);
        check({name, "_done"}, int'(done), 0);
        check({name, "_rd_addr"}, int'(mem_rd_addr), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pat;
        bit         found;
        int         first_valid_cyc;
        int         done_before;

        pat = 8'b1011_0010;
        rst_n = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.out_ready = 1'b1;

        // 1: reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 2: addr 5, len 4, full-rate consumer
        send_cmd(5, 4);
        found = 0;
        first_valid_cyc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                found = 1;
                first_valid_cyc = cyc;
                break;
            end
        end
        check("b2_first_valid_seen", int'(found), 1);
        check("b2_first_valid_latency", first_valid_cyc - accept_cyc, 2);
        check("b2_busy", int'(busy), 1);
        wait_done("b2", 1'b0);
        check("b2_back_to_back", last_pop_cyc - first_valid_cyc, 4);

        // 3: address wrap 1022..1 -> data 254,255,0,1
        @(posedge clk);
        #1;
        send_cmd(1022, 4);
        wait_done("b3", 1'b0);

        // 4: len 16 with stall then irregular ready
        @(posedge clk);
        #1;
        words_popped = 0;
        send_cmd(0, 16);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (words_popped >= 4) break;
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (5) @(posedge clk);
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0) break;
            #1 bus.out_ready = pat[i % 8];
            @(posedge clk);
        end
        #1 bus.out_ready = 1'b1;
        check("b4_all_words", words_popped, 16);
        wait_done("b4", 1'b0);

        // 5: zero-length command
        @(posedge clk);
        #1;
        send_cmd(100, 0);
        check("b5_no_valid", int'(bus.out_valid), 0);
        wait_done("b5", 1'b1);

        // 6: reset during word 3 of an 8-word burst, then a clean burst
        @(posedge clk);
        #1;
        send_cmd(40, 8);
        found = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_data == 8'd42) begin
                found = 1;
                break;
            end
        end
        check("b6_word3_seen", int'(found), 1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        check_reset_outputs("b6_abort");
        done_before = done_cnt;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("b6_no_done_after_abort", done_cnt, done_before);
        send_cmd(20, 2);
        wait_done("b6", 1'b0);

        repeat (3) @(posedge clk);
        check("end_queue_empty", exp_q.size(), 0);
        check("end_done_count", done_cnt, 5);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
